// File: rtl/shifter_4bit.sv
// shifter_4bit -- registered fixed-distance shifter / rotator.
//
// Each rising clk edge samples x, applies a compile-time shift (direction,
// type and distance fixed by parameters) and registers the result on y.
// The default build is a 4-bit logical left shift by one.
//
// Parameters:
//   WIDTH      data width of x and y (2..32)
//   SHIFT_AMT  shift distance (0..31)
//   SHIFT_DIR  0 = left (toward MSB), 1 = right (toward LSB)
//   SHIFT_TYPE 0 = logical, 1 = arithmetic, 2 = rotate (3 is rejected)
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, forces y to 0
//   x    in   WIDTH-bit word, sampled every cycle
//   y    out  WIDTH-bit registered result, one cycle after x
module shifter_4bit #(
  parameter int WIDTH      = 4,
  parameter int SHIFT_AMT  = 1,
  parameter int SHIFT_DIR  = 0,
  parameter int SHIFT_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Rotation only needs the distance modulo the word width.
  localparam int ROT_AMT = SHIFT_AMT % WIDTH;

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  // Parameter legality is checked while elaborating, so a bad build never
  // produces a netlist.
  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("shifter_4bit: WIDTH must be in 2..32");
    end
    if (SHIFT_AMT < 0 || SHIFT_AMT > 31) begin : g_bad_amt
      $error("shifter_4bit: SHIFT_AMT must be in 0..31");
    end
    if (SHIFT_DIR != 0 && SHIFT_DIR != 1) begin : g_bad_dir
      $error("shifter_4bit: SHIFT_DIR must be 0 or 1");
    end
    if (SHIFT_TYPE < 0 || SHIFT_TYPE > 2) begin : g_bad_type
      $error("shifter_4bit: SHIFT_TYPE must be 0, 1 or 2");
    end
  endgenerate

  // Only one branch survives elaboration: the datapath is fixed wiring.
  // SV shifts by a distance >= WIDTH already yield zero (logical) or full
  // sign replication (>>> on a signed operand), which covers the large
  // distance cases without extra logic.
  generate
    if (SHIFT_TYPE == 2) begin : g_rotate
      if (SHIFT_DIR == 0) begin : g_rol
        // With ROT_AMT = 0 the right-hand term shifts by WIDTH and is zero.
        assign y_d = (x << ROT_AMT) | (x >> (WIDTH - ROT_AMT));
      end else begin : g_ror
        assign y_d = (x >> ROT_AMT) | (x << (WIDTH - ROT_AMT));
      end
    end else if (SHIFT_TYPE == 1 && SHIFT_DIR == 1) begin : g_asr
      assign y_d = $unsigned($signed(x) >>> SHIFT_AMT);
    end else if (SHIFT_DIR == 1) begin : g_lsr
      assign y_d = x >> SHIFT_AMT;
    end else begin : g_lsl
      // Arithmetic left is the same operation as logical left.
      assign y_d = x << SHIFT_AMT;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_shifter_4bit.sv
// tb_shifter_4bit -- directed self-checking bench for shifter_4bit.
// Several parameterisations share one clock, reset and input word; each
// step drives x/rst, waits for an edge, and checks the relevant outputs.
module tb_shifter_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic [3:0] y_dflt, y_rotr, y_asr, y_lsr, y_amt0, y_lsl4, y_rol5, y_asr6;

  int tests_run = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shifter_4bit u_dflt (.clk(clk), .rst(rst), .x(x), .y(y_dflt));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(1), .SHIFT_DIR(1), .SHIFT_TYPE(2))
    u_rotr (.clk(clk), .rst(rst), .x(x), .y(y_rotr));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(1), .SHIFT_DIR(1), .SHIFT_TYPE(1))
    u_asr (.clk(clk), .rst(rst), .x(x), .y(y_asr));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(1), .SHIFT_DIR(1), .SHIFT_TYPE(0))
    u_lsr (.clk(clk), .rst(rst), .x(x), .y(y_lsr));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(0), .SHIFT_DIR(0), .SHIFT_TYPE(0))
    u_amt0 (.clk(clk), .rst(rst), .x(x), .y(y_amt0));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(4), .SHIFT_DIR(0), .SHIFT_TYPE(0))
    u_lsl4 (.clk(clk), .rst(rst), .x(x), .y(y_lsl4));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(5), .SHIFT_DIR(0), .SHIFT_TYPE(2))
    u_rol5 (.clk(clk), .rst(rst), .x(x), .y(y_rol5));
  shifter_4bit #(.WIDTH(4), .SHIFT_AMT(6), .SHIFT_DIR(1), .SHIFT_TYPE(1))
    u_asr6 (.clk(clk), .rst(rst), .x(x), .y(y_asr6));

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp)
      else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic [3:0] v);
    rst = r;
    x   = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    x   = 4'hF;

    // Reset held for two edges with x = F.
    step(1'b1, 4'hF);
    check("reset_edge1", y_dflt, 4'h0);
    check("reset_edge1_asr6", y_asr6, 4'h0);
    step(1'b1, 4'hF);
    check("reset_edge2", y_dflt, 4'h0);
    check("reset_edge2_rotr", y_rotr, 4'h0);
    step(1'b0, 4'hF);
    check("reset_release", y_dflt, 4'hE);
    check("lsl4_F", y_lsl4, 4'h0);
    check("asr6_F", y_asr6, 4'hF);

    // Default exhaustive sweep: y = (2*x) mod 16.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic [3:0] e;
      v = 4'(i);
      e = 4'((2 * i) % 16);
      step(1'b0, v);
      check($sformatf("sweep_x%0h", v), y_dflt, e);
    end

    // Latency: x=3 then x=0.
    step(1'b0, 4'h3);
    check("latency_n", y_dflt, 4'h6);
    step(1'b0, 4'h0);
    check("latency_n1", y_dflt, 4'h0);

    // Output must not follow x between edges.
    x = 4'h7;
    #2;
    check("no_comb_path", y_dflt, 4'h0);

    // Mid-stream reset.
    step(1'b0, 4'h5);
    check("stream_5", y_dflt, 4'hA);
    step(1'b1, 4'h6);
    check("midreset_rst", y_dflt, 4'h0);
    step(1'b0, 4'h6);
    check("midreset_release", y_dflt, 4'hC);
    check("rotr_6", y_rotr, 4'h3);
    check("asr_6", y_asr, 4'h3);
    check("asr6_6", y_asr6, 4'h0);

    // A reset pulse entirely between edges has no effect.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("short_rst_hold", y_dflt, 4'hC);
    step(1'b0, 4'h7);
    check("short_rst_next", y_dflt, 4'hE);

    // Variants at distance 1.
    step(1'b0, 4'h1);
    check("rotr_1", y_rotr, 4'h8);
    check("lsr_1", y_lsr, 4'h0);
    check("asr_1", y_asr, 4'h0);
    step(1'b0, 4'h8);
    check("asr_8", y_asr, 4'hC);
    check("lsr_8", y_lsr, 4'h4);
    check("rotr_8", y_rotr, 4'h4);
    check("dflt_8", y_dflt, 4'h0);

    // Distance boundaries.
    step(1'b0, 4'hA);
    check("amt0_A", y_amt0, 4'hA);
    check("dflt_A", y_dflt, 4'h4);
    step(1'b0, 4'h9);
    check("rol5_9", y_rol5, 4'h3);
    check("asr6_9", y_asr6, 4'hF);
    check("dflt_9", y_dflt, 4'h2);
    check("lsl4_9", y_lsl4, 4'h0);
    step(1'b0, 4'h6);
    check("rol5_6", y_rol5, 4'hC);
    check("amt0_6", y_amt0, 4'h6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
